// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency MULT/DIV ops that commit into HI/LO,
// plus MTHI/MTLO writes and MFHI/MFLO reads through MDUOut.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        Flush,
    input  logic [3:0]  MDUCtrl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    ph_q, ph_d;
    logic [31:0]    pl_q, pl_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;

    logic           accept;
    logic [63:0]    prodS, prodU;
    logic [31:0]    absA, absB, divisorS, divisorU;
    logic [31:0]    qMag, rMag, quotS, remS, quotU, remU;
    logic           divByZero;

    assign prodS = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
    assign prodU = {32'd0, SrcA} * {32'd0, SrcB};

    // Signed divide works on magnitudes; the divisor is forced to 1 on zero so the
    // arithmetic stays defined, and the result is discarded in that case anyway.
    assign divByZero = (SrcB == 32'd0);
    assign absA      = SrcA[31] ? (~SrcA + 32'd1) : SrcA;
    assign absB      = SrcB[31] ? (~SrcB + 32'd1) : SrcB;
    assign divisorS  = divByZero ? 32'd1 : absB;
    assign divisorU  = divByZero ? 32'd1 : SrcB;
    assign qMag      = absA / divisorS;
    assign rMag      = absA % divisorS;
    assign quotS     = (SrcA[31] ^ SrcB[31]) ? (~qMag + 32'd1) : qMag;
    assign remS      = SrcA[31] ? (~rMag + 32'd1) : rMag;
    assign quotU     = SrcA / divisorU;
    assign remU      = SrcA % divisorU;

    assign accept = Start & ~Flush & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (MDUCtrl)
                        OP_MULT: begin
                            state_d      = S_MUL;
                            cnt_d        = MUL_LOAD;
                            {ph_d, pl_d} = prodS;
                        end
                        OP_MULTU: begin
                            state_d      = S_MUL;
                            cnt_d        = MUL_LOAD;
                            {ph_d, pl_d} = prodU;
                        end
                        OP_DIV: begin
                            state_d = S_DIV;
                            cnt_d   = DIV_LOAD;
                            ph_d    = divByZero ? hi_q : remS;
                            pl_d    = divByZero ? lo_q : quotS;
                        end
                        OP_DIVU: begin
                            state_d = S_DIV;
                            cnt_d   = DIV_LOAD;
                            ph_d    = divByZero ? hi_q : remU;
                            pl_d    = divByZero ? lo_q : quotU;
                        end
                        OP_MTHI: hi_d = SrcA;
                        OP_MTLO: lo_d = SrcA;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    hi_d    = ph_q;
                    lo_d    = pl_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q != S_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        MDUOut = 32'd0;
        if (MDUCtrl == OP_MFHI) MDUOut = hi_q;
        else if (MDUCtrl == OP_MFLO) MDUOut = lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: a table of directed MDU operations plus hand-written
// sequences for reset, ignored starts, flush and move/read behaviour.
module tb_e_mdu;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        Flush;
    logic [3:0]  MDUCtrl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int total = 0;
    int bad   = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Flush  (Flush),
        .MDUCtrl(MDUCtrl),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO),
        .MDUOut (MDUOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] preHi;
        logic [31:0] preLo;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expBusy;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one accepted-candidate instruction for a single cycle, then scrambles the operands.
    task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        Start   = 1'b1;
        Flush   = 1'b0;
        MDUCtrl = ctrl;
        SrcA    = a;
        SrcB    = b;
        tick();
        Start   = 1'b0;
        MDUCtrl = NONE;
        SrcA    = 32'h1234_5678;
        SrcB    = 32'h0BAD_F00D;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (Busy === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{MULT,  32'hFFFFFFFF, 32'h00000002, 32'h11, 32'h22, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h11, 32'h22, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'h11, 32'h22, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h11, 32'h22, 32'h00000000, 32'h80000000, 10};
        vecs[4]  = '{DIVU,  32'h00000005, 32'h00000000, 32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};
        vecs[5]  = '{DIVU,  32'h00000064, 32'h00000007, 32'h11, 32'h22, 32'h00000002, 32'h0000000E, 10};
        vecs[6]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h11, 32'h22, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7]  = '{MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h11, 32'h22, 32'h00000000, 32'h0000000F, 5};
        vecs[8]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11, 32'h22, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[9]  = '{DIV,   32'h00000009, 32'h00000000, 32'hAAAA, 32'hBBBB, 32'h0000AAAA, 32'h0000BBBB, 10};
        vecs[10] = '{MULT,  32'h80000000, 32'h80000000, 32'h11, 32'h22, 32'h40000000, 32'h00000000, 5};
        vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h11, 32'h22, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[12] = '{DIV,   32'hFFFFFF9C, 32'h00000007, 32'h11, 32'h22, 32'hFFFFFFFE, 32'hFFFFFFF2, 10};

        reset   = 1'b0;
        Start   = 1'b1;
        Flush   = 1'b0;
        MDUCtrl = MULT;
        SrcA    = 32'hFFFFFFFF;
        SrcB    = 32'h00000002;

        // Held reset with a MULT requested must never start or commit anything.
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("reset busy %0d", i), {31'd0, Busy}, 32'd0);
        end
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        Start   = 1'b0;
        MDUCtrl = NONE;
        reset   = 1'b1;
        tick();
        checkOutput("post-reset busy", {31'd0, Busy}, 32'd0);
        checkOutput("post-reset HI", HI, 32'd0);

        for (int v = 0; v < 13; v++) begin
            applyStimulus(MTHI, vecs[v].preHi, 32'd0);
            applyStimulus(MTLO, vecs[v].preLo, 32'd0);
            checkOutput($sformatf("vec%0d preload HI", v), HI, vecs[v].preHi);
            applyStimulus(vecs[v].ctrl, vecs[v].a, vecs[v].b);
            waitIdle(cyc);
            checkOutput($sformatf("vec%0d busy cycles", v), cyc, vecs[v].expBusy);
            checkOutput($sformatf("vec%0d HI", v), HI, vecs[v].expHi);
            checkOutput($sformatf("vec%0d LO", v), LO, vecs[v].expLo);
        end

        // Starts, moves and flushes while busy are all ignored.
        applyStimulus(MTHI, 32'h0, 32'd0);
        applyStimulus(MULT, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("busy hold %0d", i), {31'd0, Busy}, 32'd1);
            Start   = 1'b1;
            Flush   = i[0];
            MDUCtrl = (i == 2) ? MTHI : MULT;
            SrcA    = 32'd100 + i;
            SrcB    = 32'd100;
            tick();
        end
        Start   = 1'b0;
        Flush   = 1'b0;
        MDUCtrl = NONE;
        waitIdle(cyc);
        checkOutput("ignored-start busy cycles", cyc + 3, 32'd5);
        checkOutput("ignored-start HI", HI, 32'd0);
        checkOutput("ignored-start LO", LO, 32'd12);

        // Start with Flush in the same cycle is cancelled.
        Start   = 1'b1;
        Flush   = 1'b1;
        MDUCtrl = MULT;
        SrcA    = 32'd7;
        SrcB    = 32'd7;
        tick();
        Start   = 1'b0;
        Flush   = 1'b0;
        MDUCtrl = NONE;
        checkOutput("flushed start busy", {31'd0, Busy}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("flushed start LO", LO, 32'd12);

        // Move then read back through MDUOut.
        applyStimulus(MTLO, 32'hDEADBEEF, 32'd0);
        checkOutput("MTLO busy", {31'd0, Busy}, 32'd0);
        MDUCtrl = MFLO;
        Start   = 1'b1;
        #1;
        checkOutput("MFLO MDUOut", MDUOut, 32'hDEADBEEF);
        MDUCtrl = MFHI;
        #1;
        checkOutput("MFHI MDUOut", MDUOut, 32'h0);
        MDUCtrl = NONE;
        #1;
        checkOutput("NONE MDUOut", MDUOut, 32'h0);
        Start = 1'b0;
        tick();

        // Reset in the fourth busy cycle of a DIV discards it.
        applyStimulus(MTHI, 32'h55, 32'd0);
        applyStimulus(MTLO, 32'h66, 32'd0);
        applyStimulus(DIV, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        checkOutput("mid-div busy", {31'd0, Busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("mid-div reset busy", {31'd0, Busy}, 32'd0);
        checkOutput("mid-div reset HI", HI, 32'd0);
        checkOutput("mid-div reset LO", LO, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        checkOutput("after discard busy", {31'd0, Busy}, 32'd0);
        checkOutput("after discard LO", LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
